// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg -- shared constants and types for the float-to-int pipeline.
//
// Contents:
//   FP_BIAS / FP_EXP_SAT  : single-precision exponent bias and the first biased
//                           exponent whose magnitude no longer fits in int32
//   INT32_MAX / INT32_MIN : saturation values
//   FLAG_INVALID/INEXACT  : bit positions inside out_flags (FTOI_FLAGS_EN)
//   align_t               : stage-1 payload handed from ftoi_align to stage 2
// -----------------------------------------------------------------------------
package fpu_pkg;

   localparam int unsigned FP_BIAS    = 127;
   localparam int unsigned FP_EXP_SAT = 158;

   localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] INT32_MIN = 32'h8000_0000;

   localparam int unsigned FLAG_INVALID = 1;
   localparam int unsigned FLAG_INEXACT = 0;

   // field holds |x| * 2 truncated: bits [31:1] are the integer part and
   // bit 0 is the guard (first discarded) bit used for rounding.
   typedef struct packed {
      logic        sign;
      logic        sat;      // result is a saturation constant
      logic        sat_neg;  // pick INT32_MIN rather than INT32_MAX
      logic [31:0] field;
   } align_t;

endpackage

// File: rtl/ftoi_align.sv
// -----------------------------------------------------------------------------
// ftoi_align -- combinational stage-1 decode and mantissa alignment.
//
// Ports:
//   in_data_i : IEEE-754 single-precision operand
//   flags_o   : {invalid, inexact}, present only when FTOI_FLAGS_EN is defined
//   s1_o      : decoded sign / saturation info and the aligned magnitude field
//
// Optional feature macro: FTOI_FLAGS_EN (adds flags_o and its logic).
// -----------------------------------------------------------------------------
module ftoi_align
   import fpu_pkg::*;
(
   input  logic [31:0] in_data_i,
`ifdef FTOI_FLAGS_EN
   output logic [1:0]  flags_o,
`endif
   output align_t      s1_o
);

   // Unbiased exponent at or above which the value overflows int32.
   localparam logic signed [8:0] E_SAT   = 9'(FP_EXP_SAT - FP_BIAS);
   // At this exponent the mantissa LSB has weight 2^-1, i.e. it sits exactly
   // on the guard bit, so no shift is needed.
   localparam logic signed [8:0] E_ALIGN = 9'sd22;
   // Below this exponent |x| < 0.5 and the rounded result is always zero.
   localparam logic signed [8:0] E_MIN   = -9'sd1;

   logic              sign;
   logic [7:0]        bexp;
   logic [22:0]       frac;
   logic [23:0]       mant;
   logic signed [8:0] exp_unb;
   logic [8:0]        rsh_amt;
   logic [8:0]        lsh_amt;
   logic              sat_range;
   logic              is_nan;
   logic [31:0]       field;

   assign sign      = in_data_i[31];
   assign bexp      = in_data_i[30:23];
   assign frac      = in_data_i[22:0];
   // Subnormals get a zero hidden bit; their exponent is far below E_MIN anyway.
   assign mant      = {bexp != 8'd0, frac};
   assign exp_unb   = $signed({1'b0, bexp}) - $signed(9'(FP_BIAS));
   assign rsh_amt   = E_ALIGN - exp_unb;
   assign lsh_amt   = exp_unb - E_ALIGN;
   // Covers Inf and NaN too, since biased 255 is far above the limit.
   assign sat_range = (exp_unb >= E_SAT);
   assign is_nan    = (bexp == 8'hFF) && (frac != 23'd0);

`ifdef FTOI_FLAGS_EN
   logic lost;
   logic exact_min;
   logic invalid;

   // -2^31 is the one value with the saturating exponent that is representable.
   assign exact_min = sign && (exp_unb == E_SAT) && (frac == 23'd0);
`endif

   // NOTE: every signal written here gets a default first, so no path through
   // the if/else chain can leave it unassigned and infer a latch.
   always_comb begin
      field = '0;
`ifdef FTOI_FLAGS_EN
      lost  = 1'b0;
`endif
      if (sat_range) begin
         field = '0;
      end else if (exp_unb < E_MIN) begin
`ifdef FTOI_FLAGS_EN
         lost = |mant;
`endif
      end else if (exp_unb >= E_ALIGN) begin
         // lsh_amt is 0..8 here; 24 + 8 bits fill the 32-bit field exactly.
         field = {8'd0, mant} << lsh_amt;
      end else begin
         // rsh_amt is 1..23 here.
         field = {8'd0, mant} >> rsh_amt;
`ifdef FTOI_FLAGS_EN
         lost  = |(mant & ~(24'hFF_FFFF << rsh_amt));
`endif
      end
   end

   assign s1_o.sign    = sign;
   assign s1_o.sat     = sat_range;
   assign s1_o.sat_neg = sign && !is_nan;   // every NaN saturates positive
   assign s1_o.field   = field;

`ifdef FTOI_FLAGS_EN
   assign invalid               = sat_range && !exact_min;
   assign flags_o[FLAG_INVALID] = invalid;
   assign flags_o[FLAG_INEXACT] = !invalid && (field[0] || lost);
`endif

endmodule

// File: rtl/ftoi_pipe.sv
// -----------------------------------------------------------------------------
// ftoi_pipe -- 2-stage float32 to int32 converter with valid/ready handshake.
//   stage 1 : decode and align (ftoi_align), registered into s1_*
//   stage 2 : round half away from zero, negate, saturate, registered to out_*
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready ignores in_valid)
//   in_data              : IEEE-754 single-precision operand
//   out_valid / out_ready: result handshake; outputs hold while stalled
//   out_data             : two's-complement int32 result
//   out_flags            : {invalid, inexact}, only when FTOI_FLAGS_EN is defined
//
// Optional feature macro: FTOI_FLAGS_EN.
// -----------------------------------------------------------------------------
module ftoi_pipe
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
`ifdef FTOI_FLAGS_EN
   output logic [1:0]  out_flags,
`endif
   output logic [31:0] out_data
);

   align_t      s1_d;
   align_t      s1_q;
   logic        s1_valid_q;
   logic        out_valid_q;
   logic [31:0] out_data_d;
   logic [31:0] out_data_q;
   logic [31:0] mag;
   logic        s2_free;
   logic        s1_adv;
   logic        accept;

`ifdef FTOI_FLAGS_EN
   logic [1:0]  flags_d;
   logic [1:0]  s1_flags_q;
   logic [1:0]  out_flags_q;
`endif

   // ---------------------------------------------------------------- handshake
   assign s2_free  = !out_valid_q || out_ready;
   assign s1_adv   = s1_valid_q && s2_free;
   assign in_ready = !s1_valid_q || s1_adv;
   assign accept   = in_valid && in_ready;

   // ---------------------------------------------------------------- stage 1
   ftoi_align u_align (
      .in_data_i (in_data),
`ifdef FTOI_FLAGS_EN
      .flags_o   (flags_d),
`endif
      .s1_o      (s1_d)
   );

   // NOTE: stage-1 payload has no reset; s1_valid_q gates every use of it, so
   // its power-up contents never reach the outputs.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_q <= s1_d;
`ifdef FTOI_FLAGS_EN
         s1_flags_q <= flags_d;
`endif
      end
   end

   // ---------------------------------------------------------------- stage 2
   always_comb begin
      // Integer part plus the guard bit: ties round away from zero.
      mag = {1'b0, s1_q.field[31:1]} + {31'd0, s1_q.field[0]};
      if (s1_q.sat) begin
         out_data_d = s1_q.sat_neg ? INT32_MIN : INT32_MAX;
      end else if (s1_q.sign) begin
         out_data_d = -mag;
      end else begin
         out_data_d = mag;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef FTOI_FLAGS_EN
         out_flags_q <= '0;
`endif
      end else begin
         if (in_ready) begin
            s1_valid_q <= in_valid;
         end
         if (s2_free) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               out_data_q <= out_data_d;
`ifdef FTOI_FLAGS_EN
               out_flags_q <= s1_flags_q;
`endif
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
`ifdef FTOI_FLAGS_EN
   assign out_flags = out_flags_q;
`endif

endmodule
